alu_core: RTL and testbench

- Registered arithmetic/logic/shift datapath: one arithmetic unit, one logic unit and one shift unit share operands A and B.
- A 5-bit opcode selects the unit and its operation; the result and flags are captured on the rising clock edge.
- Sits in the CPU execute stage between the register-file read ports and the writeback/flags register.

---
 rtl/alu_core.sv | 188 ++++++++++++++++++
 tb/tb_alu_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered execute-stage ALU: arithmetic, logic and shift units share operands A/B.
// opcode[4:3] picks the unit, opcode[2:0] the operation; Y/C/Z update one cycle later.
module alu_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            opcode,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  C,
    output logic                  Z
);

    localparam logic [1:0] UNIT_AU  = 2'b00;
    localparam logic [1:0] UNIT_LU  = 2'b01;
    localparam logic [1:0] UNIT_SHU = 2'b10;

    localparam logic [2:0] AU_ADD   = 3'b000;
    localparam logic [2:0] AU_SUB   = 3'b001;
    localparam logic [2:0] AU_INCA  = 3'b010;
    localparam logic [2:0] AU_DECA  = 3'b011;
    localparam logic [2:0] AU_NEGA  = 3'b100;
    localparam logic [2:0] AU_INCB  = 3'b101;
    localparam logic [2:0] AU_DECB  = 3'b110;
    localparam logic [2:0] AU_PASSA = 3'b111;

    localparam logic [1:0] LU_AND = 2'b00;
    localparam logic [1:0] LU_OR  = 2'b01;
    localparam logic [1:0] LU_XOR = 2'b10;
    localparam logic [1:0] LU_NOT = 2'b11;

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W = {DATA_WIDTH{1'b1}};

    function automatic logic is_zero(input logic [DATA_WIDTH-1:0] v);
        return (v == ZERO_W);
    endfunction

    logic [DATA_WIDTH-1:0] au_x_s;
    logic [DATA_WIDTH-1:0] au_y_s;
    logic                  au_cin_s;
    logic [DATA_WIDTH:0]   au_sum_s;

    logic [DATA_WIDTH-1:0] lu_y_s;
    logic [DATA_WIDTH-1:0] shu_y_s;
    logic                  shu_c_s;

    logic [DATA_WIDTH-1:0] res_y_s;
    logic                  res_c_s;
    logic                  res_z_s;

    logic [DATA_WIDTH-1:0] y_r;
    logic                  c_r;
    logic                  z_r;

    // Arithmetic operand steering: every AU op is x + y + cin on one adder.
    always_comb begin
        au_x_s   = A;
        au_y_s   = ZERO_W;
        au_cin_s = 1'b0;
        case (opcode[2:0])
            AU_ADD: begin
                au_x_s   = A;
                au_y_s   = B;
                au_cin_s = 1'b0;
            end
            AU_SUB: begin
                au_x_s   = A;
                au_y_s   = ~B;
                au_cin_s = 1'b1;
            end
            AU_INCA: begin
                au_x_s   = A;
                au_y_s   = ZERO_W;
                au_cin_s = 1'b1;
            end
            AU_DECA: begin
                au_x_s   = A;
                au_y_s   = ONES_W;
                au_cin_s = 1'b0;
            end
            AU_NEGA: begin
                au_x_s   = ~A;
                au_y_s   = ZERO_W;
                au_cin_s = 1'b1;
            end
            AU_INCB: begin
                au_x_s   = B;
                au_y_s   = ZERO_W;
                au_cin_s = 1'b1;
            end
            AU_DECB: begin
                au_x_s   = B;
                au_y_s   = ONES_W;
                au_cin_s = 1'b0;
            end
            AU_PASSA: begin
                au_x_s   = A;
                au_y_s   = ZERO_W;
                au_cin_s = 1'b0;
            end
            default: begin
                au_x_s   = A;
                au_y_s   = ZERO_W;
                au_cin_s = 1'b0;
            end
        endcase
    end

    // The extra MSB of the sum is the carry-out flag.
    assign au_sum_s = {1'b0, au_x_s} + {1'b0, au_y_s} + {ZERO_W, au_cin_s};

    // Bitwise logic unit; opcode[2] is a don't-care here.
    always_comb begin
        lu_y_s = ZERO_W;
        case (opcode[1:0])
            LU_AND:  lu_y_s = A & B;
            LU_OR:   lu_y_s = A | B;
            LU_XOR:  lu_y_s = A ^ B;
            LU_NOT:  lu_y_s = ~A;
            default: lu_y_s = ZERO_W;
        endcase
    end

    // One-bit logical shifter; the bit shifted out becomes the carry.
    always_comb begin
        shu_y_s = ZERO_W;
        shu_c_s = 1'b0;
        if (opcode[0]) begin
            shu_y_s = {1'b0, A[DATA_WIDTH-1:1]};
            shu_c_s = A[0];
        end else begin
            shu_y_s = {A[DATA_WIDTH-2:0], 1'b0};
            shu_c_s = A[DATA_WIDTH-1];
        end
    end

    // Unit select; the reserved unit yields zero, so its Z comes out as 1.
    always_comb begin
        res_y_s = ZERO_W;
        res_c_s = 1'b0;
        case (opcode[4:3])
            UNIT_AU: begin
                res_y_s = au_sum_s[DATA_WIDTH-1:0];
                res_c_s = au_sum_s[DATA_WIDTH];
            end
            UNIT_LU: begin
                res_y_s = lu_y_s;
                res_c_s = 1'b0;
            end
            UNIT_SHU: begin
                res_y_s = shu_y_s;
                res_c_s = shu_c_s;
            end
            default: begin
                res_y_s = ZERO_W;
                res_c_s = 1'b0;
            end
        endcase
    end

    assign res_z_s = is_zero(res_y_s);

    // Result/flag register: reset wins over enable, disabled cycles hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r <= ZERO_W;
            c_r <= 1'b0;
            z_r <= 1'b0;
        end else if (en) begin
            y_r <= res_y_s;
            c_r <= res_c_s;
            z_r <= res_z_s;
        end else begin
            y_r <= y_r;
            c_r <= c_r;
            z_r <= z_r;
        end
    end

    assign Y = y_r;
    assign C = c_r;
    assign Z = z_r;

endmodule

// File: tb/tb_alu_core.sv
// Directed and randomised checks of alu_core (DATA_WIDTH=8) with immediate assertions.
module tb_alu_core;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] A;
    logic [7:0] B;
    logic [4:0] opcode;
    logic [7:0] Y;
    logic       C;
    logic       Z;

    int vectors;
    int miscompares;

    alu_core #(.DATA_WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .Y      (Y),
        .C      (C),
        .Z      (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent integer-arithmetic model returning {Y, C, Z}.
    function automatic logic [9:0] ref_model(input int a, input int b, input logic [4:0] op);
        int   y;
        logic c;
        y = 0;
        c = 1'b0;
        case (op[4:3])
            2'b00: begin
                case (op[2:0])
                    3'd0: begin y = a + b; c = (y > 255); end
                    3'd1: begin y = a - b; c = (a >= b); end
                    3'd2: begin y = a + 1; c = (a == 255); end
                    3'd3: begin y = a - 1; c = (a != 0); end
                    3'd4: begin y = 0 - a; c = (a == 0); end
                    3'd5: begin y = b + 1; c = (b == 255); end
                    3'd6: begin y = b - 1; c = (b != 0); end
                    default: begin y = a; c = 1'b0; end
                endcase
            end
            2'b01: begin
                case (op[1:0])
                    2'd0: y = a & b;
                    2'd1: y = a | b;
                    2'd2: y = a ^ b;
                    default: y = ~a;
                endcase
            end
            2'b10: begin
                if (op[0]) begin
                    y = a / 2;
                    c = (a % 2) == 1;
                end else begin
                    y = a * 2;
                    c = (a >= 128);
                end
            end
            default: begin y = 0; c = 1'b0; end
        endcase
        y = y & 255;
        return {y[7:0], c, (y[7:0] == 8'h00)};
    endfunction

    task automatic step(input logic [7:0] a_v, input logic [7:0] b_v, input logic [4:0] op_v,
                        input logic en_v, input logic reset_v);
        A      = a_v;
        B      = b_v;
        opcode = op_v;
        en     = en_v;
        reset  = reset_v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] ey, input logic ec, input logic ez);
        vectors++;
        assert ({Y, C, Z} === {ey, ec, ez}) else begin
            miscompares++;
            $error("FAIL %s: got Y=%h C=%b Z=%b, expected Y=%h C=%b Z=%b", tag, Y, C, Z, ey, ec, ez);
        end
    endtask

    initial begin
        logic [9:0] exp_v;
        logic [7:0] ra;
        logic [7:0] rb;
        vectors     = 0;
        miscompares = 0;

        step(8'h12, 8'h34, 5'b00000, 1'b1, 1'b1);
        step(8'h12, 8'h34, 5'b00000, 1'b1, 1'b1);
        check("reset_state", 8'h00, 1'b0, 1'b0);

        step(8'hF0, 8'h20, 5'b00000, 1'b1, 1'b0);
        check("add_wrap", 8'h10, 1'b1, 1'b0);
        step(8'h05, 8'h05, 5'b00001, 1'b1, 1'b0);
        check("sub_equal", 8'h00, 1'b1, 1'b1);
        step(8'h03, 8'h05, 5'b00001, 1'b1, 1'b0);
        check("sub_borrow", 8'hFE, 1'b0, 1'b0);

        step(8'hFF, 8'h00, 5'b00010, 1'b1, 1'b0);
        check("inca_wrap", 8'h00, 1'b1, 1'b1);
        step(8'h00, 8'h00, 5'b00011, 1'b1, 1'b0);
        check("deca_zero", 8'hFF, 1'b0, 1'b0);
        step(8'h01, 8'h77, 5'b00100, 1'b1, 1'b0);
        check("nega_one", 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'h77, 5'b00100, 1'b1, 1'b0);
        check("nega_zero", 8'h00, 1'b1, 1'b1);
        step(8'h33, 8'hFF, 5'b00101, 1'b1, 1'b0);
        check("incb_wrap", 8'h00, 1'b1, 1'b1);
        step(8'h33, 8'h00, 5'b00110, 1'b1, 1'b0);
        check("decb_zero", 8'hFF, 1'b0, 1'b0);
        step(8'h9C, 8'h11, 5'b00111, 1'b1, 1'b0);
        check("passa", 8'h9C, 1'b0, 1'b0);

        step(8'hAA, 8'h0F, 5'b01000, 1'b1, 1'b0);
        check("lu_and", 8'h0A, 1'b0, 1'b0);
        step(8'hAA, 8'h0F, 5'b01001, 1'b1, 1'b0);
        check("lu_or", 8'hAF, 1'b0, 1'b0);
        step(8'hAA, 8'h0F, 5'b01110, 1'b1, 1'b0);
        check("lu_xor_bit2", 8'hA5, 1'b0, 1'b0);
        step(8'hAA, 8'h0F, 5'b01011, 1'b1, 1'b0);
        check("lu_not", 8'h55, 1'b0, 1'b0);

        step(8'h81, 8'hFF, 5'b10000, 1'b1, 1'b0);
        check("shl", 8'h02, 1'b1, 1'b0);
        step(8'h81, 8'hFF, 5'b10001, 1'b1, 1'b0);
        check("shr", 8'h40, 1'b1, 1'b0);
        step(8'h80, 8'h00, 5'b10001, 1'b1, 1'b0);
        check("shr_c0", 8'h40, 1'b0, 1'b0);
        step(8'h80, 8'h00, 5'b10110, 1'b1, 1'b0);
        check("shl_out_zero", 8'h00, 1'b1, 1'b1);

        step(8'h81, 8'h00, 5'b10001, 1'b1, 1'b0);
        check("pre_hold", 8'h40, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'hFF - 8'(i), 8'h5A, 5'(i * 7), 1'b0, 1'b0);
            check("hold", 8'h40, 1'b1, 1'b0);
        end

        step(8'hFF, 8'hFF, 5'b11010, 1'b1, 1'b0);
        check("reserved_11010", 8'h00, 1'b0, 1'b1);
        step(8'h12, 8'h34, 5'b11111, 1'b1, 1'b0);
        check("reserved_11111", 8'h00, 1'b0, 1'b1);

        step(8'hFF, 8'h01, 5'b00000, 1'b1, 1'b0);
        check("add_to_zero", 8'h00, 1'b1, 1'b1);
        step(8'h11, 8'h22, 5'b00000, 1'b1, 1'b1);
        check("reset_midstream", 8'h00, 1'b0, 1'b0);
        step(8'h11, 8'h22, 5'b00000, 1'b1, 1'b0);
        check("post_reset_add", 8'h33, 1'b0, 1'b0);

        for (int op = 0; op < 32; op++) begin
            for (int k = 0; k < 4; k++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                exp_v = ref_model(int'(ra), int'(rb), 5'(op));
                step(ra, rb, 5'(op), 1'b1, 1'b0);
                check("random", exp_v[9:2], exp_v[1], exp_v[0]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
